// File: rtl/mii_udp_rx.sv
// mii_udp_rx: MII (4-bit) receive path that terminates one UDP port.
// Strips preamble/SFD, assembles bytes from low/high nibbles, filters the
// Ethernet, IPv4 and UDP headers against the local MAC/IP/port, streams the
// UDP payload out, and at end of frame pulses rx_done with a frame-good
// verdict (CRC residue, no rx_er, byte-aligned end, payload complete).
//
// Ports:
//   mii_rx_clk     PHY receive clock, all logic on its rising edge
//   rst_n          asynchronous active-low reset
//   mii_rx_dv      receive data valid
//   mii_rx_er      receive error
//   mii_rx_da      receive nibble, low nibble of each byte first
//   payload_data   UDP payload byte
//   payload_valid  one-cycle strobe for payload_data
//   payload_sop    first payload byte (with payload_valid)
//   payload_eop    last payload byte (with payload_valid)
//   rx_src_ip      source IP of the current/last accepted frame
//   rx_src_port    source UDP port of the current/last accepted frame
//   rx_len         payload byte count (UDP length - 8)
//   rx_done        one-cycle end-of-frame pulse for accepted frames
//   rx_crc_ok      frame good, valid while rx_done=1
module mii_udp_rx #(
  parameter logic [47:0] LOCAL_MAC  = 48'h00_0a_35_01_fe_c0,
  parameter logic [31:0] LOCAL_IP   = 32'hc0_a8_00_02,
  parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
  input  logic        mii_rx_clk,
  input  logic        rst_n,
  input  logic        mii_rx_dv,
  input  logic        mii_rx_er,
  input  logic [3:0]  mii_rx_da,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_sop,
  output logic        payload_eop,
  output logic [31:0] rx_src_ip,
  output logic [15:0] rx_src_port,
  output logic [15:0] rx_len,
  output logic        rx_done,
  output logic        rx_crc_ok
);

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_ETH, S_IP, S_UDP, S_PAYLOAD, S_TAIL, S_DROP
  } state_t;

  state_t      state;
  logic        armed;      // a dv=0 has been seen since reset; safe to sync
  logic        phase;      // 0: expecting low nibble, 1: expecting high nibble
  logic [3:0]  lo_nib;
  logic [4:0]  cnt;        // byte index within the current header
  logic [15:0] pay_cnt;
  logic        ucast_ok;
  logic        bcast_ok;
  logic [31:0] src_ip_tmp;
  logic [15:0] src_port_tmp;
  logic [7:0]  len_hi;
  logic [15:0] len_tmp;
  logic [31:0] crc;
  logic        err;

  logic [7:0]  byte_w;
  logic        byte_done;
  logic        in_frame;
  logic        ucast_now;
  logic        bcast_now;
  logic        hdr_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [2:0] i);
    case (i)
      3'd0:    return LOCAL_MAC[47:40];
      3'd1:    return LOCAL_MAC[39:32];
      3'd2:    return LOCAL_MAC[31:24];
      3'd3:    return LOCAL_MAC[23:16];
      3'd4:    return LOCAL_MAC[15:8];
      3'd5:    return LOCAL_MAC[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [1:0] i);
    case (i)
      2'd0:    return LOCAL_IP[31:24];
      2'd1:    return LOCAL_IP[23:16];
      2'd2:    return LOCAL_IP[15:8];
      default: return LOCAL_IP[7:0];
    endcase
  endfunction

  assign byte_w    = {mii_rx_da, lo_nib};
  assign byte_done = mii_rx_dv && phase;
  assign in_frame  = (state == S_ETH) || (state == S_IP) || (state == S_UDP) ||
                     (state == S_PAYLOAD) || (state == S_TAIL);
  assign ucast_now = ucast_ok && (byte_w == mac_byte(cnt[2:0]));
  assign bcast_now = bcast_ok && (byte_w == 8'hFF);

  // Header field check for the byte completing this cycle.
  always_comb begin
    hdr_bad = 1'b0;
    case (state)
      S_ETH: begin
        case (cnt)
          5'd5:    hdr_bad = !(ucast_now || bcast_now);
          5'd12:   hdr_bad = (byte_w != 8'h08);
          5'd13:   hdr_bad = (byte_w != 8'h00);
          default: hdr_bad = 1'b0;
        endcase
      end
      S_IP: begin
        case (cnt)
          5'd0:                       hdr_bad = (byte_w != 8'h45);
          5'd9:                       hdr_bad = (byte_w != 8'h11);
          5'd16, 5'd17, 5'd18, 5'd19: hdr_bad = (byte_w != ip_byte(cnt[1:0]));
          default:                    hdr_bad = 1'b0;
        endcase
      end
      S_UDP: begin
        case (cnt)
          5'd2:    hdr_bad = (byte_w != LOCAL_PORT[15:8]);
          5'd3:    hdr_bad = (byte_w != LOCAL_PORT[7:0]);
          5'd5:    hdr_bad = ({len_hi, byte_w} < 16'd8);
          default: hdr_bad = 1'b0;
        endcase
      end
      default: hdr_bad = 1'b0;
    endcase
  end

  always_ff @(posedge mii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      armed         <= 1'b0;
      phase         <= 1'b0;
      lo_nib        <= 4'd0;
      cnt           <= 5'd0;
      pay_cnt       <= 16'd0;
      ucast_ok      <= 1'b0;
      bcast_ok      <= 1'b0;
      src_ip_tmp    <= 32'd0;
      src_port_tmp  <= 16'd0;
      len_hi        <= 8'd0;
      len_tmp       <= 16'd0;
      crc           <= 32'hFFFFFFFF;
      err           <= 1'b0;
      payload_data  <= 8'd0;
      payload_valid <= 1'b0;
      payload_sop   <= 1'b0;
      payload_eop   <= 1'b0;
      rx_src_ip     <= 32'd0;
      rx_src_port   <= 16'd0;
      rx_len        <= 16'd0;
      rx_done       <= 1'b0;
      rx_crc_ok     <= 1'b0;
    end else begin
      payload_valid <= 1'b0;
      payload_sop   <= 1'b0;
      payload_eop   <= 1'b0;
      rx_done       <= 1'b0;
      rx_crc_ok     <= 1'b0;

      if (!mii_rx_dv) begin
        // End of carrier: report accepted frames, then resync in IDLE.
        phase <= 1'b0;
        armed <= 1'b1;
        case (state)
          S_PAYLOAD: rx_done <= 1'b1;
          S_TAIL: begin
            rx_done   <= 1'b1;
            rx_crc_ok <= (crc == CRC_RESIDUE) && !err && !phase;
          end
          default: ;
        endcase
        state <= S_IDLE;
      end else begin
        phase <= ~phase;
        if (!phase) lo_nib <= mii_rx_da;
        if (in_frame && byte_done) crc <= crc_byte(crc, byte_w);
        if (in_frame && mii_rx_er) err <= 1'b1;

        case (state)
          S_IDLE: begin
            // Entering PREAMBLE only on a 5 guarantees the SFD follows at least one 5.
            if (armed && mii_rx_da == 4'h5) state <= S_PREAMBLE;
            else                            state <= S_DROP;
          end
          S_PREAMBLE: begin
            if (mii_rx_da == 4'hD) begin
              state    <= S_ETH;
              phase    <= 1'b0;
              crc      <= 32'hFFFFFFFF;
              err      <= 1'b0;
              cnt      <= 5'd0;
              ucast_ok <= 1'b1;
              bcast_ok <= 1'b1;
            end else if (mii_rx_da != 4'h5) begin
              state <= S_DROP;
            end
          end
          S_ETH: begin
            if (byte_done) begin
              ucast_ok <= ucast_now;
              bcast_ok <= bcast_now;
              if (hdr_bad)              state <= S_DROP;
              else if (cnt == 5'd13) begin
                state <= S_IP;
                cnt   <= 5'd0;
              end else                  cnt <= cnt + 5'd1;
            end
          end
          S_IP: begin
            if (byte_done) begin
              if (cnt >= 5'd12 && cnt <= 5'd15) src_ip_tmp <= {src_ip_tmp[23:0], byte_w};
              if (hdr_bad)              state <= S_DROP;
              else if (cnt == 5'd19) begin
                state <= S_UDP;
                cnt   <= 5'd0;
              end else                  cnt <= cnt + 5'd1;
            end
          end
          S_UDP: begin
            if (byte_done) begin
              case (cnt)
                5'd0:    src_port_tmp[15:8] <= byte_w;
                5'd1:    src_port_tmp[7:0]  <= byte_w;
                5'd4:    len_hi             <= byte_w;
                5'd5:    len_tmp            <= {len_hi, byte_w} - 16'd8;
                default: ;
              endcase
              if (hdr_bad) state <= S_DROP;
              else if (cnt == 5'd7) begin
                // Header accepted: publish sender info before any payload strobe.
                rx_src_ip   <= src_ip_tmp;
                rx_src_port <= src_port_tmp;
                rx_len      <= len_tmp;
                pay_cnt     <= 16'd0;
                cnt         <= 5'd0;
                state       <= (len_tmp == 16'd0) ? S_TAIL : S_PAYLOAD;
              end else cnt <= cnt + 5'd1;
            end
          end
          S_PAYLOAD: begin
            if (byte_done) begin
              payload_data  <= byte_w;
              payload_valid <= 1'b1;
              payload_sop   <= (pay_cnt == 16'd0);
              payload_eop   <= (pay_cnt == rx_len - 16'd1);
              pay_cnt       <= pay_cnt + 16'd1;
              if (pay_cnt == rx_len - 16'd1) state <= S_TAIL;
            end
          end
          default: ;  // TAIL and DROP hold until dv falls
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mii_udp_rx.sv
module tb_mii_udp_rx;

  localparam logic [47:0] MAC   = 48'h00_0a_35_01_fe_c0;
  localparam logic [31:0] IP    = 32'hc0_a8_00_02;
  localparam logic [15:0] PORT  = 16'd5000;
  localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mii_rx_dv;
  logic        mii_rx_er;
  logic [3:0]  mii_rx_da;
  logic [7:0]  payload_data;
  logic        payload_valid, payload_sop, payload_eop;
  logic [31:0] rx_src_ip;
  logic [15:0] rx_src_port, rx_len;
  logic        rx_done, rx_crc_ok;

  mii_udp_rx #(.LOCAL_MAC(MAC), .LOCAL_IP(IP), .LOCAL_PORT(PORT)) dut (
    .mii_rx_clk(clk), .rst_n(rst_n), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .mii_rx_da(mii_rx_da), .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_sop(payload_sop), .payload_eop(payload_eop), .rx_src_ip(rx_src_ip),
    .rx_src_port(rx_src_port), .rx_len(rx_len), .rx_done(rx_done), .rx_crc_ok(rx_crc_ok)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmp_n = 0;
  int fail_n = 0;

  logic [7:0]  frame[$];
  int          n_str, n_done;
  logic [7:0]  st_data[16];
  int          st_cyc[16];
  logic        st_sop[16], st_eop[16];
  logic        dn_ok[8];
  int          dn_cyc[8];
  int          pay_hi_cyc, low_cyc;
  logic [15:0] rst_len;
  logic [31:0] rst_ip;

  // Output recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (payload_valid) begin
        if (n_str < 16) begin
          st_data[n_str] = payload_data;
          st_cyc[n_str]  = cyc;
          st_sop[n_str]  = payload_sop;
          st_eop[n_str]  = payload_eop;
        end
        n_str = n_str + 1;
      end
      if (rx_done) begin
        if (n_done < 8) begin
          dn_ok[n_done]  = rx_crc_ok;
          dn_cyc[n_done] = cyc;
        end
        n_done = n_done + 1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int j = 0; j < 8; j++) begin
      fb = r[0] ^ b[j];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                             input logic [15:0] dport, input logic [15:0] ulen,
                             input logic [31:0] sip, input logic [15:0] sport);
    logic [31:0] c;
    logic [15:0] tot;
    frame.delete();
    for (int i = 5; i >= 0; i--) frame.push_back(dmac[8*i +: 8]);
    frame.push_back(8'h02); frame.push_back(8'h00); frame.push_back(8'h00);
    frame.push_back(8'h00); frame.push_back(8'h00); frame.push_back(8'h01);
    frame.push_back(etype[15:8]); frame.push_back(etype[7:0]);
    tot = ulen + 16'd20;
    frame.push_back(8'h45); frame.push_back(8'h00);
    frame.push_back(tot[15:8]); frame.push_back(tot[7:0]);
    frame.push_back(8'h00); frame.push_back(8'h00);
    frame.push_back(8'h40); frame.push_back(8'h00);
    frame.push_back(8'h40); frame.push_back(8'h11);
    frame.push_back(8'h00); frame.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frame.push_back(sip[8*i +: 8]);
    for (int i = 3; i >= 0; i--) frame.push_back(IP[8*i +: 8]);
    frame.push_back(sport[15:8]); frame.push_back(sport[7:0]);
    frame.push_back(dport[15:8]); frame.push_back(dport[7:0]);
    frame.push_back(ulen[15:8]);  frame.push_back(ulen[7:0]);
    frame.push_back(8'h00); frame.push_back(8'h00);
    for (int k = 1; k <= int'(ulen) - 8; k++) frame.push_back(8'(k));
    c = 32'hFFFFFFFF;
    foreach (frame[i]) c = crc_next(c, frame[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frame.push_back(c[8*i +: 8]);
  endtask

  task automatic drive_nib(input logic dv, input logic [3:0] d, input logic er);
    @(negedge clk);
    mii_rx_dv = dv;
    mii_rx_da = d;
    mii_rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_nib(1'b0, 4'h0, 1'b0);
  endtask

  // stop_at < 0 sends the whole frame; er_at / rst_at < 0 disable those events.
  task automatic send_frame(input int stop_at, input int er_at, input int rst_at, input int gap);
    int n;
    for (int i = 0; i < 15; i++) drive_nib(1'b1, 4'h5, 1'b0);
    drive_nib(1'b1, 4'hD, 1'b0);
    n = (stop_at < 0) ? frame.size() : stop_at;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #2 rst_len = rx_len;
        rst_ip = rx_src_ip;
        rst_n = 1'b1;
      end
      drive_nib(1'b1, frame[i][3:0], 1'b0);
      drive_nib(1'b1, frame[i][7:4], i == er_at);
      if (i == 42) pay_hi_cyc = cyc + 1;
    end
    drive_nib(1'b0, 4'h0, 1'b0);
    low_cyc = cyc + 1;
    if (gap > 1) idle(gap - 1);
  endtask

  task automatic clear_mon();
    n_str  = 0;
    n_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mii_rx_dv = 1'b0; mii_rx_er = 1'b0; mii_rx_da = 4'h0;
    clear_mon();
    repeat (3) @(negedge clk);
    cmp_n++; if ({payload_valid, payload_sop, payload_eop, rx_done, rx_crc_ok} !== 5'b0) begin fail_n++; $display("FAIL reset_strobes got %b want 00000", {payload_valid, payload_sop, payload_eop, rx_done, rx_crc_ok}); end
    cmp_n++; if (payload_data !== 8'h00) begin fail_n++; $display("FAIL reset_data got %h want 00", payload_data); end
    cmp_n++; if ({rx_src_ip, rx_src_port, rx_len} !== 64'd0) begin fail_n++; $display("FAIL reset_info got %h want 0", {rx_src_ip, rx_src_port, rx_len}); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_good_frame();
    clear_mon();
    build_frame(MAC, 16'h0800, PORT, 16'd12, 32'hc0a80064, 16'h04d2);
    send_frame(-1, -1, -1, 4);
    idle(2);
    cmp_n++; if (n_str !== 4) begin fail_n++; $display("FAIL good_count got %0d want 4", n_str); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (st_data[i] !== 8'(i + 1)) begin fail_n++; $display("FAIL good_data[%0d] got %h want %h", i, st_data[i], 8'(i + 1)); end
      cmp_n++; if ({st_sop[i], st_eop[i]} !== {i == 0, i == 3}) begin fail_n++; $display("FAIL good_sopeop[%0d] got %b%b want %b%b", i, st_sop[i], st_eop[i], i == 0, i == 3); end
    end
    for (int i = 1; i < 4; i++) begin
      cmp_n++; if (st_cyc[i] - st_cyc[i-1] !== 2) begin fail_n++; $display("FAIL good_spacing[%0d] got %0d want 2", i, st_cyc[i] - st_cyc[i-1]); end
    end
    cmp_n++; if (st_cyc[0] !== pay_hi_cyc) begin fail_n++; $display("FAIL good_first_latency got cycle %0d want %0d", st_cyc[0], pay_hi_cyc); end
    cmp_n++; if (rx_len !== 16'd4) begin fail_n++; $display("FAIL good_len got %0d want 4", rx_len); end
    cmp_n++; if (rx_src_port !== 16'h04d2) begin fail_n++; $display("FAIL good_port got %h want 04d2", rx_src_port); end
    cmp_n++; if (rx_src_ip !== 32'hc0a80064) begin fail_n++; $display("FAIL good_ip got %h want c0a80064", rx_src_ip); end
    cmp_n++; if (n_done !== 1) begin fail_n++; $display("FAIL good_done_count got %0d want 1", n_done); end
    cmp_n++; if (dn_ok[0] !== 1'b1) begin fail_n++; $display("FAIL good_crc_ok got %b want 1", dn_ok[0]); end
    cmp_n++; if (dn_cyc[0] !== low_cyc) begin fail_n++; $display("FAIL good_done_time got %0d want %0d", dn_cyc[0], low_cyc); end
    cmp_n++; if (rx_crc_ok !== 1'b0) begin fail_n++; $display("FAIL good_crc_ok_clear got %b want 0", rx_crc_ok); end
  endtask

  task automatic test_bad_fcs();
    clear_mon();
    build_frame(MAC, 16'h0800, PORT, 16'd12, 32'hc0a80064, 16'h04d2);
    frame[frame.size() - 1] = frame[frame.size() - 1] ^ 8'h10;
    send_frame(-1, -1, -1, 4);
    idle(2);
    cmp_n++; if (n_str !== 4) begin fail_n++; $display("FAIL fcs_count got %0d want 4", n_str); end
    cmp_n++; if ({st_data[0], st_data[1], st_data[2], st_data[3]} !== 32'h01020304) begin fail_n++; $display("FAIL fcs_data got %h want 01020304", {st_data[0], st_data[1], st_data[2], st_data[3]}); end
    cmp_n++; if (n_done !== 1) begin fail_n++; $display("FAIL fcs_done_count got %0d want 1", n_done); end
    cmp_n++; if (dn_ok[0] !== 1'b0) begin fail_n++; $display("FAIL fcs_crc_ok got %b want 0", dn_ok[0]); end
  endtask

  task automatic test_filter();
    clear_mon();
    build_frame(MAC, 16'h0800, 16'd5001, 16'd12, 32'h0a000001, 16'h1111);
    send_frame(-1, -1, -1, 4);
    idle(2);
    cmp_n++; if (n_str !== 0) begin fail_n++; $display("FAIL port_strobes got %0d want 0", n_str); end
    cmp_n++; if (n_done !== 0) begin fail_n++; $display("FAIL port_done got %0d want 0", n_done); end
    cmp_n++; if (rx_src_port !== 16'h04d2) begin fail_n++; $display("FAIL port_hold got %h want 04d2", rx_src_port); end
    clear_mon();
    build_frame(MAC, 16'h0806, PORT, 16'd12, 32'h0a000001, 16'h1111);
    send_frame(-1, -1, -1, 4);
    idle(2);
    cmp_n++; if (n_str !== 0) begin fail_n++; $display("FAIL etype_strobes got %0d want 0", n_str); end
    cmp_n++; if (n_done !== 0) begin fail_n++; $display("FAIL etype_done got %0d want 0", n_done); end
    cmp_n++; if (rx_len !== 16'd4) begin fail_n++; $display("FAIL etype_len_hold got %0d want 4", rx_len); end
  endtask

  task automatic test_rx_er();
    clear_mon();
    build_frame(MAC, 16'h0800, PORT, 16'd12, 32'hc0a80064, 16'h04d2);
    send_frame(-1, 43, -1, 4);
    idle(2);
    cmp_n++; if (n_str !== 4) begin fail_n++; $display("FAIL er_count got %0d want 4", n_str); end
    cmp_n++; if (st_eop[3] !== 1'b1) begin fail_n++; $display("FAIL er_eop got %b want 1", st_eop[3]); end
    cmp_n++; if (n_done !== 1) begin fail_n++; $display("FAIL er_done_count got %0d want 1", n_done); end
    cmp_n++; if (dn_ok[0] !== 1'b0) begin fail_n++; $display("FAIL er_crc_ok got %b want 0", dn_ok[0]); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    build_frame(MAC, 16'h0800, PORT, 16'd12, 32'hc0a80064, 16'h04d2);
    send_frame(44, -1, -1, 1);
    build_frame(MAC, 16'h0800, PORT, 16'd12, 32'hc0a80065, 16'h2222);
    send_frame(-1, -1, -1, 4);
    idle(2);
    cmp_n++; if (n_str !== 6) begin fail_n++; $display("FAIL b2b_count got %0d want 6", n_str); end
    cmp_n++; if ({st_data[0], st_data[1]} !== 16'h0102) begin fail_n++; $display("FAIL b2b_trunc_data got %h want 0102", {st_data[0], st_data[1]}); end
    cmp_n++; if ({st_sop[0], st_eop[0], st_sop[1], st_eop[1]} !== 4'b1000) begin fail_n++; $display("FAIL b2b_trunc_flags got %b want 1000", {st_sop[0], st_eop[0], st_sop[1], st_eop[1]}); end
    cmp_n++; if ({st_data[2], st_data[3], st_data[4], st_data[5]} !== 32'h01020304) begin fail_n++; $display("FAIL b2b_data got %h want 01020304", {st_data[2], st_data[3], st_data[4], st_data[5]}); end
    cmp_n++; if ({st_sop[2], st_eop[5]} !== 2'b11) begin fail_n++; $display("FAIL b2b_sopeop got %b want 11", {st_sop[2], st_eop[5]}); end
    cmp_n++; if (n_done !== 2) begin fail_n++; $display("FAIL b2b_done_count got %0d want 2", n_done); end
    cmp_n++; if ({dn_ok[0], dn_ok[1]} !== 2'b01) begin fail_n++; $display("FAIL b2b_crc_ok got %b want 01", {dn_ok[0], dn_ok[1]}); end
    cmp_n++; if ({rx_src_ip, rx_src_port} !== {32'hc0a80065, 16'h2222}) begin fail_n++; $display("FAIL b2b_src got %h want c0a800652222", {rx_src_ip, rx_src_port}); end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    build_frame(MAC, 16'h0800, PORT, 16'd12, 32'hc0a80064, 16'h04d2);
    send_frame(-1, -1, 43, 4);
    idle(2);
    cmp_n++; if ({rst_len, rst_ip} !== 48'd0) begin fail_n++; $display("FAIL midrst_clear got %h want 0", {rst_len, rst_ip}); end
    cmp_n++; if (n_str !== 0) begin fail_n++; $display("FAIL midrst_strobes got %0d want 0", n_str); end
    cmp_n++; if (n_done !== 0) begin fail_n++; $display("FAIL midrst_done got %0d want 0", n_done); end
    clear_mon();
    send_frame(-1, -1, -1, 4);
    idle(2);
    cmp_n++; if (n_str !== 4 || n_done !== 1) begin fail_n++; $display("FAIL midrst_recover got %0d strobes %0d done want 4 1", n_str, n_done); end
    cmp_n++; if (dn_ok[0] !== 1'b1) begin fail_n++; $display("FAIL midrst_recover_ok got %b want 1", dn_ok[0]); end
  endtask

  task automatic test_bcast_empty();
    clear_mon();
    build_frame(BCAST, 16'h0800, PORT, 16'd8, 32'h0a0b0c0d, 16'h3333);
    send_frame(-1, -1, -1, 4);
    idle(2);
    cmp_n++; if (n_str !== 0) begin fail_n++; $display("FAIL bcast_strobes got %0d want 0", n_str); end
    cmp_n++; if (rx_len !== 16'd0) begin fail_n++; $display("FAIL bcast_len got %0d want 0", rx_len); end
    cmp_n++; if (rx_src_ip !== 32'h0a0b0c0d) begin fail_n++; $display("FAIL bcast_ip got %h want 0a0b0c0d", rx_src_ip); end
    cmp_n++; if (n_done !== 1) begin fail_n++; $display("FAIL bcast_done_count got %0d want 1", n_done); end
    cmp_n++; if (dn_ok[0] !== 1'b1) begin fail_n++; $display("FAIL bcast_crc_ok got %b want 1", dn_ok[0]); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_filter();
    test_rx_er();
    test_back_to_back();
    test_reset_midframe();
    test_bcast_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule

// File: doc/mii_udp_rx.md
# mii_udp_rx

Receive-side counterpart of the MII UDP transmit path. It runs in the PHY receive clock domain and takes the 4-bit MII receive stream from the PHY. It strips preamble and SFD, assembles bytes, filters on the Ethernet, IPv4 and UDP headers, and delivers the UDP payload as a byte stream. At end of frame it reports the sender address and an FCS verdict. It sits between the PHY's MII receive pins and the user-side UDP consumer logic.

## Interface
Parameters:
- LOCAL_MAC, 48'h00_0a_35_01_fe_c0, accepted destination MAC (broadcast FF:FF:FF:FF:FF:FF is also accepted)
- LOCAL_IP, 32'hc0_a8_00_02, accepted destination IPv4 address
- LOCAL_PORT, 16'd5000, accepted UDP destination port

Ports:
- mii_rx_clk  in  1  25 MHz PHY receive clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mii_rx_dv  in  1  receive data valid
- mii_rx_er  in  1  receive error
- mii_rx_da  in  4  receive nibble, low nibble of each byte first
- payload_data  out  8  UDP payload byte
- payload_valid  out  1  one-cycle strobe, payload_data valid
- payload_sop  out  1  with payload_valid, first payload byte
- payload_eop  out  1  with payload_valid, last payload byte
- rx_src_ip  out  32  source IP of the current or last accepted frame
- rx_src_port  out  16  source UDP port of the current or last accepted frame
- rx_len  out  16  payload byte count (UDP length − 8)
- rx_done  out  1  one-cycle end-of-frame pulse for accepted frames
- rx_crc_ok  out  1  frame good, valid while rx_done=1

## Operation
- Reset: all outputs 0 and FSM in IDLE.
- Nibble assembly: a phase bit toggles on each nibble while mii_rx_dv=1. Byte = {second nibble, first nibble}. The phase bit clears when mii_rx_dv=0.
- FSM states:
  - IDLE: on dv=1, go to PREAMBLE.
  - PREAMBLE: nibbles of 4'h5. Nibble 4'hD after at least one 5 sets byte phase to 0 and goes to ETH_HDR. Any other nibble goes to DROP.
  - ETH_HDR: 14 bytes. Destination must equal LOCAL_MAC or broadcast. EtherType must be 16'h0800.
  - IP_HDR: 20 bytes. First byte must be 8'h45. Protocol (byte 9) must be 8'h11. Destination IP (bytes 16–19) must equal LOCAL_IP. Source IP is captured into rx_src_ip.
  - UDP_HDR: 8 bytes. Source port goes to rx_src_port. Destination port must equal LOCAL_PORT. UDP length L is captured, and rx_len = L−8.
  - PAYLOAD: emits rx_len bytes, then goes to TAIL. If rx_len=0, go straight to TAIL with no payload strobes.
  - TAIL: consumes pad and FCS until dv=0.
  - DROP: waits for dv=0, then IDLE.
- Any header mismatch goes to DROP. A dropped frame produces no payload strobes and no rx_done.
- The IP header checksum is not checked. L<8 is a mismatch.
- CRC-32: reflected polynomial 32'hEDB88320, initialised to 32'hFFFFFFFF at SFD. It is updated per byte from destination MAC through FCS inclusive. The frame is good when the register equals 32'hDEBB20E3 at end of frame.
- rx_crc_ok=1 only if all of the following hold:
  - CRC residue matches
  - mii_rx_er never seen after SFD
  - frame ended on a byte boundary
  - dv stayed high until the payload was complete
- mii_rx_er=1 in an accepted frame: no FSM change; the error is latched and forces rx_crc_ok=0.
- dv falls during PAYLOAD: rx_done pulses with rx_crc_ok=0, and payload_eop is never issued.
- Payload bytes are not withheld pending the CRC result; consumers discard them on rx_crc_ok=0.

## Timing
- payload_valid is a 1-cycle pulse, in the cycle after the high nibble of the byte is sampled. Consecutive strobes are spaced exactly 2 cycles apart.
- payload_sop/eop coincide with the matching strobe. With rx_len=1, sop and eop are both set on the same strobe.
- rx_src_ip, rx_src_port and rx_len are stable before the first payload_valid and held until the next accepted UDP header.
- rx_done pulses for 1 cycle, one cycle after dv is sampled low. rx_crc_ok is valid in that cycle and returns to 0 after it.
- A new frame (dv=1) in the cycle immediately after dv=0 is accepted: IDLE→PREAMBLE with no dead cycle.
- Asynchronous reset mid-frame: outputs clear immediately. After release, the FSM stays in IDLE/DROP until dv=0 before syncing.

## Test plan
- Good frame: preamble 15×5 + D, matching MAC/IP/port, UDP L=12, payload 01 02 03 04, correct FCS. Required:
  - 4 strobes 2 cycles apart with data 01..04
  - sop on 01, eop on 04
  - rx_len=4, rx_src_port and rx_src_ip match the sent values
  - rx_done=1 with rx_crc_ok=1
- Same frame with one FCS bit flipped → identical payload, rx_done with rx_crc_ok=0.
- Wrong destination port 5001, and separately EtherType 0x0806 → no payload_valid, no rx_done.
- mii_rx_er pulsed for one cycle mid-payload → payload still delivered, rx_crc_ok=0.
- dv dropped after 2 of 4 payload bytes → 2 strobes, no eop, rx_done with rx_crc_ok=0. A back-to-back good frame afterwards is received correctly.
- Broadcast MAC with L=8 → no strobes, rx_len=0, rx_done with rx_crc_ok=1.
